phy_tx_lane_serializer: RTL
===========================

Name: phy_tx_lane_serializer

Overview:
- Single-clock, parametrised successor to the 4-lane tree-of-2:1-muxes PCIe transmit path.
- Accepts one parallel word of LANES lanes × WIDTH bits and serialises it onto one WIDTH-bit stream, one lane per clk cycle, lane 0 first.
- A one-word pending buffer sustains back-to-back words with no bubbles. Lanes flagged invalid emit IDLE_SYM.
- Recirculation: words presented with in_valid low go to the probe (tester) port instead of the serialiser.

Parameters:
- LANES, 4, number of input lanes; ≥2, power of 2.
- WIDTH, 8, bits per lane and per output symbol.
- IDLE_SYM, 8'hBC, symbol driven on data_out when no valid lane is being sent; WIDTH bits.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset_L  input  1  synchronous, active-low reset.
- in_data  input  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- in_lane_valid  input  LANES  per-lane valid, captured with the word.
- in_valid  input  1  word valid; when low, in_data is recirculated to the probe port.
- in_ready  output  1  word can be accepted this cycle.
- data_out  output  WIDTH  serial symbol, registered.
- valid_out  output  1  data_out carries a valid lane, registered.
- probe_data  output  LANES*WIDTH  recirculated word, registered.
- probe_valid  output  1  probe_data updated this cycle.
- busy  output  1  shifter active or pending buffer full.

Behaviour:
- Reset (reset_L=0 at an edge) sets:
  - data_out=IDLE_SYM, valid_out=0.
  - probe_data=0, probe_valid=0.
  - shifter idle, slot counter=0, pending empty.
- in_ready is 0 while reset_L=0. Reset mid-word discards the shifter and pending contents; the next cycle is idle.
- State machine (2 states, plus a slot counter 0..LANES-1):
  - IDLE: nothing to send.
  - SEND: shifter holds a word; one lane is emitted per cycle.
- in_ready is combinational: reset_L & (!pending_full | (state==SEND & slot==LANES-1)).
- A word is accepted at an edge where in_valid & in_ready.
- Load rules:
  - If IDLE, or in SEND at slot LANES-1 with pending empty, the accepted word loads the shifter directly.
  - Otherwise the accepted word goes to the pending buffer.
  - At the end of slot LANES-1, a full pending buffer moves to the shifter, and slot restarts at 0. This happens in the same edge as any new acceptance into pending.
  - At the end of slot LANES-1 with pending empty and no accept, the block returns to IDLE.
- Output:
  - On a load edge, data_out<=lane 0 and valid_out<=in_lane_valid[0]. Latency is 1 cycle from the accept edge to the first symbol.
  - Each following edge emits the next lane.
  - For a lane whose valid bit is 0: data_out<=IDLE_SYM, valid_out<=0.
  - In IDLE: data_out<=IDLE_SYM, valid_out<=0.
- Throughput: one word per LANES cycles, continuous while words are offered.
- A word with all lane-valids 0 is still accepted and occupies LANES idle slots.
- Recirculation:
  - When in_valid=0 at an edge (and reset_L=1): probe_data<=in_data and probe_valid<=1.
  - Otherwise probe_valid<=0 and probe_data holds.
  - When in_valid=1 but in_ready=0, the word is neither accepted nor recirculated; the sender must hold it.
- busy = (state==SEND) | pending_full.

Test Plan:
All scenarios use LANES=4, WIDTH=8.
- Reset: hold reset_L=0 for 3 cycles with in_valid=1 -> data_out=8'hBC, valid_out=0, probe_valid=0, probe_data=0, in_ready=0, busy=0 throughout.
- Single word: in_data=32'h44332211, lane valid 4'hF, one-cycle in_valid pulse accepted at edge t -> after edges t..t+3, data_out = 11, 22, 33, 44 with valid_out=1; after edge t+4, data_out=BC, valid_out=0.
- Back-to-back: A=32'h44332211, B=32'h88776655, C=32'hCCBBAA99 offered continuously from t ->
  - A accepted at t, B at t+1 (pending).
  - in_ready=0 for cycles t+1..t+2 and returns to 1 in the slot-3 cycle; C accepted at t+4.
  - 12 consecutive valid symbols 11..CC with no bubble.
- Lane mask: in_data=32'h44332211, in_lane_valid=4'b0101 -> output sequence 11/v1, BC/v0, 33/v1, BC/v0.
- Recirculation: in_valid=0, in_data=32'hDEADBEEF while word A is serialising -> next cycle probe_data=32'hDEADBEEF and probe_valid=1, then probe_valid=0; A's output stream is unchanged.
- Mid-word reset: reset_L=0 for one edge after lane 1 of A, with B pending -> next cycle data_out=BC, valid_out=0, busy=0; B is never emitted.

Source files
------------

// File: rtl/phy_tx_lane_serializer.sv
// Serialises a LANES x WIDTH word onto one WIDTH-bit stream, lane 0 first; first symbol 1 cycle after accept.
// One-word pending buffer gives bubble-free back-to-back words; in_ready drops while pending is full outside the last slot.
module phy_tx_lane_serializer #(
  parameter int              LANES    = 4,
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_lane_valid,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic [LANES*WIDTH-1:0] probe_data,
  output logic                   probe_valid,
  output logic                   busy
);

  localparam int SLOT_W = $clog2(LANES);
  localparam int WORD_W = LANES * WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [SLOT_W-1:0]   slot, slot_nxt;
  logic [WORD_W-1:0]   shift_dat, shift_dat_nxt;
  logic [LANES-1:0]    shift_lv, shift_lv_nxt;
  logic [WORD_W-1:0]   pend_dat, pend_dat_nxt;
  logic [LANES-1:0]    pend_lv, pend_lv_nxt;
  logic                pending_full, pending_full_nxt;
  logic [WIDTH-1:0]    data_out_nxt;
  logic                valid_out_nxt;
  logic                last_slot;
  logic                accept;

  assign last_slot = (state == SEND) && (slot == SLOT_W'(LANES - 1));
  assign in_ready  = reset_L & (~pending_full | last_slot);
  assign accept    = in_valid & in_ready;
  assign busy      = (state == SEND) | pending_full;

  always_comb begin
    state_nxt        = state;
    slot_nxt         = slot;
    shift_dat_nxt    = shift_dat;
    shift_lv_nxt     = shift_lv;
    pend_dat_nxt     = pend_dat;
    pend_lv_nxt      = pend_lv;
    pending_full_nxt = pending_full;
    data_out_nxt     = IDLE_SYM;
    valid_out_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt     = SEND;
          slot_nxt      = '0;
          shift_dat_nxt = in_data;
          shift_lv_nxt  = in_lane_valid;
        end
      end
      SEND: begin
        if (!last_slot) begin
          slot_nxt = slot + SLOT_W'(1);
          if (accept) begin
            pend_dat_nxt     = in_data;
            pend_lv_nxt      = in_lane_valid;
            pending_full_nxt = 1'b1;
          end
        end else begin
          slot_nxt = '0;
          // Pending word drains into the shifter; a same-edge accept refills pending.
          if (pending_full) begin
            shift_dat_nxt = pend_dat;
            shift_lv_nxt  = pend_lv;
            if (accept) begin
              pend_dat_nxt = in_data;
              pend_lv_nxt  = in_lane_valid;
            end else begin
              pending_full_nxt = 1'b0;
            end
          end else if (accept) begin
            shift_dat_nxt = in_data;
            shift_lv_nxt  = in_lane_valid;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == SEND && shift_lv_nxt[slot_nxt]) begin
      data_out_nxt  = shift_dat_nxt[slot_nxt*WIDTH +: WIDTH];
      valid_out_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state        <= IDLE;
      slot         <= '0;
      shift_dat    <= '0;
      shift_lv     <= '0;
      pend_dat     <= '0;
      pend_lv      <= '0;
      pending_full <= 1'b0;
      data_out     <= IDLE_SYM;
      valid_out    <= 1'b0;
      probe_data   <= '0;
      probe_valid  <= 1'b0;
    end else begin
      state        <= state_nxt;
      slot         <= slot_nxt;
      shift_dat    <= shift_dat_nxt;
      shift_lv     <= shift_lv_nxt;
      pend_dat     <= pend_dat_nxt;
      pend_lv      <= pend_lv_nxt;
      pending_full <= pending_full_nxt;
      data_out     <= data_out_nxt;
      valid_out    <= valid_out_nxt;
      probe_valid  <= ~in_valid;
      if (!in_valid) begin
        probe_data <= in_data;
      end
    end
  end

endmodule
